dbg_ins_injector: RTL and testbench
===================================

Name: dbg_ins_injector

Overview:
- Debug-side instruction encoder. It turns abstract debug commands (GPR/CSR read/write) into RV32I SYSTEM/LOAD instruction words.
- It injects those words one at a time into the fetch stream that feeds the pipeline decoder, and waits for each to retire.
- Data moves through CSRs dscratch0 (0x7B2) and dscratch1 (0x7B3); x8 is the save/restore scratch register.

Parameters:
- TIMEOUT, 256: cycles to wait for RETIRE/EXC on one injected instruction before aborting.
- DSCR0_ADDR, 12'h7B2: CSR address used for data exchange.
- DSCR1_ADDR, 12'h7B3: CSR address used to save x8.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  command accepted when VALID&READY
- CMD_OP  in  3  0=GPR_RD 1=GPR_WR 2=CSR_RD 3=CSR_WR 4=MEM_RD; others illegal
- CMD_REGNO  in  12  GPR index (0-31) or CSR address
- CMD_DATA  in  32  write data, or address for MEM_RD
- INS_VALID  out  1  injected instruction valid
- INS_READY  in  1  fetch accepts instruction
- INS_OUT  out  32  encoded instruction word
- RETIRE  in  1  one-cycle pulse: injected instruction retired
- EXC  in  1  one-cycle pulse: injected instruction trapped
- DSCR_WE  out  1  preload dscratch0 this cycle
- DSCR_WDATA  out  32  preload value
- DSCR_RDATA  in  32  current dscratch0 value
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  response consumed
- RSP_DATA  out  32  read result (0 for writes)
- RSP_ERR  out  1  exception, timeout or illegal command

Behaviour:
- Reset (async, RST=1) sets state=IDLE, CMD_READY=1, and forces INS_VALID, DSCR_WE, RSP_VALID, RSP_ERR, RSP_DATA, INS_OUT, step and timer to 0. Reset mid-sequence abandons it with no restore.
- States:
  - IDLE: CMD_READY=1.
  - On accept, latch op/regno/data.
    - Illegal op, or GPR op with regno>31 → RESP with ERR=1.
    - GPR_WR to x0 → RESP with ERR=0 and nothing injected.
    - WR ops and MEM_RD → PRELOAD.
    - Otherwise → ISSUE, step=0.
  - PRELOAD: one cycle with DSCR_WE=1 and DSCR_WDATA=latched data, then → ISSUE.
  - ISSUE: INS_VALID=1 and INS_OUT=encode(op,step,regno). Both stay stable until INS_READY; on handshake → WAIT and clear the timer.
  - WAIT: timer increments every cycle.
    - RETIRE → step+1. If the sequence is done → RESP; else → ISSUE.
    - EXC (priority over RETIRE in the same cycle) or timer==TIMEOUT-1 → set err.
      - If x8 is saved and not yet restored, jump to the restore step.
      - Else → RESP.
    - A second error during restore goes straight to RESP.
  - RESP: RSP_VALID=1 and RSP_DATA=DSCR_RDATA for read ops (0 for writes). Held until RSP_READY, then → IDLE.
- Sequences, one instruction in flight at a time. x8 save = csrrw x0,dscr1,x8; x8 restore = csrrs x8,dscr1,x0.
  - GPR_RD n: csrrw x0,dscr0,xn.
  - GPR_WR n: csrrs xn,dscr0,x0.
  - CSR_RD c: save; csrrs x8,c,x0; csrrw x0,dscr0,x8; restore.
  - CSR_WR c: save; csrrs x8,dscr0,x0; csrrw x0,c,x8; restore.
- Encoding:
  - CSR instructions: {csr,rs1,funct3,rd,7'b1110011}, with csrrw funct3=001 and csrrs funct3=010.
  - lw: {12'd0,rs1,3'b010,rd,7'b0000011}.
- RETIRE/EXC outside WAIT are ignored.

Optional Feature:
- Macro DBG_INJ_MEM_EN.
- Defined: MEM_RD is legal; sequence = save; csrrs x8,dscr0,x0; lw x8,0(x8); csrrw x0,dscr0,x8; restore. A load fault takes the EXC path and still restores x8.
- Undefined: op 4 is illegal → immediate RESP with ERR=1, nothing injected.

Decomposition:
- Shared package DebugParams.vh holds:
  - CMD_OP codes;
  - SYSTEM/LOAD opcodes and the csrrw/csrrs funct3 values;
  - dscratch addresses;
  - scratch register index 8;
  - state encodings.
- One natural sub-module: dbg_ins_encoder, combinational (op, step, regno) → {INS_OUT, last, saves_x8, is_restore}. The top holds the FSM, timer and handshakes.

Test Plan:
- GPR_RD x5 → INS_OUT=0x7B229073 once; on RETIRE with DSCR_RDATA=0xDEADBEEF → RSP_DATA=0xDEADBEEF, RSP_ERR=0.
- GPR_WR x7 data=0x12345678 → one-cycle DSCR_WE with WDATA=0x12345678, then INS_OUT=0x7B2023F3; GPR_WR x0 → RSP with no INS_VALID.
- CSR_RD 0x300 → INS_OUT sequence 0x7B341073, 0x30002473, 0x7B241073, 0x7B302473. INS_READY held low 3 cycles → INS_OUT stable; no second issue before RETIRE.
- CSR_RD 0x300 with EXC on the second instruction → next issued word is the restore 0x7B302473; then RSP_ERR=1.
- No RETIRE for TIMEOUT cycles on GPR_RD → RSP_ERR=1 exactly TIMEOUT cycles after the handshake; CMD_OP=7 → immediate RSP_ERR=1.
- With DBG_INJ_MEM_EN, MEM_RD addr=0x80000010 → preload, then lw word 0x00042403 third in sequence; assert RST mid-WAIT → all outputs 0, CMD_READY=1.

Source files
------------

// File: rtl/dbg_ins_injector_pkg.sv
// Shared constants, types and encode helpers for the debug instruction injector.
// DBG_INJ_MEM_EN makes the MEM_RD command legal.
package dbg_ins_injector_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned STEP_W = 3;
   localparam int unsigned REG_W  = 12;
   localparam int unsigned GPR_W  = 5;

   localparam logic [OP_W-1:0] OP_GPR_RD = 3'd0;
   localparam logic [OP_W-1:0] OP_GPR_WR = 3'd1;
   localparam logic [OP_W-1:0] OP_CSR_RD = 3'd2;
   localparam logic [OP_W-1:0] OP_CSR_WR = 3'd3;
   localparam logic [OP_W-1:0] OP_MEM_RD = 3'd4;

   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [2:0] F3_CSRRW   = 3'b001;
   localparam logic [2:0] F3_CSRRS   = 3'b010;
   localparam logic [2:0] F3_LW      = 3'b010;

   localparam logic [REG_W-1:0] DSCR0_DEF = 12'h7B2;
   localparam logic [REG_W-1:0] DSCR1_DEF = 12'h7B3;
   localparam logic [GPR_W-1:0] X0       = 5'd0;
   localparam logic [GPR_W-1:0] X8       = 5'd8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PRELOAD = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   // One encoded step: the word plus its role in the sequence.
   typedef struct packed {
      logic [XLEN-1:0] ins;
      logic            last;
      logic            saves_x8;
      logic            is_restore;
   } enc_t;

   function automatic logic [XLEN-1:0] csr_ins(input logic [REG_W-1:0] csr,
                                               input logic [GPR_W-1:0] rs1,
                                               input logic [2:0]       f3,
                                               input logic [GPR_W-1:0] rd);
      return {csr, rs1, f3, rd, OPC_SYSTEM};
   endfunction

   function automatic logic [XLEN-1:0] lw_ins(input logic [GPR_W-1:0] rs1,
                                              input logic [GPR_W-1:0] rd);
      return {12'd0, rs1, F3_LW, rd, OPC_LOAD};
   endfunction

   function automatic logic op_legal(input logic [OP_W-1:0] op);
`ifdef DBG_INJ_MEM_EN
      return op <= OP_MEM_RD;
`else
      return op <= OP_CSR_WR;
`endif
   endfunction

   function automatic logic is_gpr(input logic [OP_W-1:0] op);
      return (op == OP_GPR_RD) || (op == OP_GPR_WR);
   endfunction

   function automatic logic is_read(input logic [OP_W-1:0] op);
      return (op == OP_GPR_RD) || (op == OP_CSR_RD) || (op == OP_MEM_RD);
   endfunction

   function automatic logic needs_preload(input logic [OP_W-1:0] op);
      return (op == OP_GPR_WR) || (op == OP_CSR_WR) || (op == OP_MEM_RD);
   endfunction

   function automatic logic [STEP_W-1:0] restore_step(input logic [OP_W-1:0] op);
      return (op == OP_MEM_RD) ? 3'd4 : 3'd3;
   endfunction

endpackage

// File: rtl/dbg_ins_injector_encoder.sv
// Combinational (op, step, regno) -> instruction word and sequence flags.
// DBG_INJ_MEM_EN adds the MEM_RD load sequence.
module dbg_ins_encoder
   import dbg_ins_injector_pkg::*;
#(
   parameter logic [11:0] DSCR0_ADDR = DSCR0_DEF,
   parameter logic [11:0] DSCR1_ADDR = DSCR1_DEF
) (
   input  logic [OP_W-1:0]   op,
   input  logic [STEP_W-1:0] step,
   input  logic [REG_W-1:0]  regno,
   output enc_t              enc
);

   logic [GPR_W-1:0] gpr;
   logic [XLEN-1:0]  save_ins;
   logic [XLEN-1:0]  rest_ins;

   assign gpr      = regno[GPR_W-1:0];
   assign save_ins = csr_ins(DSCR1_ADDR, X8, F3_CSRRW, X0);
   assign rest_ins = csr_ins(DSCR1_ADDR, X0, F3_CSRRS, X8);

   always_comb begin
      enc = '0;
      case (op)
         OP_GPR_RD: begin
            enc.ins  = csr_ins(DSCR0_ADDR, gpr, F3_CSRRW, X0);
            enc.last = 1'b1;
         end
         OP_GPR_WR: begin
            enc.ins  = csr_ins(DSCR0_ADDR, X0, F3_CSRRS, gpr);
            enc.last = 1'b1;
         end
         OP_CSR_RD, OP_CSR_WR: begin
            enc.saves_x8 = 1'b1;
            case (step)
               3'd0: enc.ins = save_ins;
               3'd1: enc.ins = (op == OP_CSR_RD) ? csr_ins(regno, X0, F3_CSRRS, X8)
                                                 : csr_ins(DSCR0_ADDR, X0, F3_CSRRS, X8);
               3'd2: enc.ins = (op == OP_CSR_RD) ? csr_ins(DSCR0_ADDR, X8, F3_CSRRW, X0)
                                                 : csr_ins(regno, X8, F3_CSRRW, X0);
               default: begin
                  enc.ins        = rest_ins;
                  enc.last       = 1'b1;
                  enc.is_restore = 1'b1;
               end
            endcase
         end
`ifdef DBG_INJ_MEM_EN
         OP_MEM_RD: begin
            enc.saves_x8 = 1'b1;
            case (step)
               3'd0: enc.ins = save_ins;
               3'd1: enc.ins = csr_ins(DSCR0_ADDR, X0, F3_CSRRS, X8);
               3'd2: enc.ins = lw_ins(X8, X8);
               3'd3: enc.ins = csr_ins(DSCR0_ADDR, X8, F3_CSRRW, X0);
               default: begin
                  enc.ins        = rest_ins;
                  enc.last       = 1'b1;
                  enc.is_restore = 1'b1;
               end
            endcase
         end
`endif
         default: enc = '0;
      endcase
   end

endmodule

// File: rtl/dbg_ins_injector.sv
// Debug command sequencer: injects encoded instructions one at a time and waits for retire.
// DBG_INJ_MEM_EN (via the package/encoder) enables MEM_RD.
module dbg_ins_injector
   import dbg_ins_injector_pkg::*;
#(
   parameter int unsigned TIMEOUT    = 256,
   parameter logic [11:0] DSCR0_ADDR = DSCR0_DEF,
   parameter logic [11:0] DSCR1_ADDR = DSCR1_DEF
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                CMD_VALID,
   output logic                CMD_READY,
   input  logic [OP_W-1:0]     CMD_OP,
   input  logic [REG_W-1:0]    CMD_REGNO,
   input  logic [XLEN-1:0]     CMD_DATA,
   output logic                INS_VALID,
   input  logic                INS_READY,
   output logic [XLEN-1:0]     INS_OUT,
   input  logic                RETIRE,
   input  logic                EXC,
   output logic                DSCR_WE,
   output logic [XLEN-1:0]     DSCR_WDATA,
   input  logic [XLEN-1:0]     DSCR_RDATA,
   output logic                RSP_VALID,
   input  logic                RSP_READY,
   output logic [XLEN-1:0]     RSP_DATA,
   output logic                RSP_ERR
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

   state_t             state;
   logic [OP_W-1:0]    op_q;
   logic [REG_W-1:0]   regno_q;
   logic [STEP_W-1:0]  step_q;
   logic [TMR_W-1:0]   timer;
   logic               err_q;
   enc_t               cur_q;

   logic [OP_W-1:0]    enc_op;
   logic [REG_W-1:0]   enc_regno;
   logic [STEP_W-1:0]  enc_step;
   enc_t               enc;
   logic               wait_err;
   logic               can_restore;

   assign INS_OUT     = cur_q.ins;
   assign wait_err    = EXC || (timer == TMR_W'(TIMEOUT - 1));
   assign can_restore = cur_q.saves_x8 && (step_q != '0) && !cur_q.is_restore;

   // Encoder looks at the step about to be issued, so INS_OUT loads on the transition.
   always_comb begin
      enc_op    = op_q;
      enc_regno = regno_q;
      enc_step  = step_q;
      if (state == S_IDLE) begin
         enc_op    = CMD_OP;
         enc_regno = CMD_REGNO;
         enc_step  = '0;
      end else if (state == S_WAIT) begin
         enc_step = wait_err ? restore_step(op_q) : STEP_W'(step_q + 3'd1);
      end
   end

   dbg_ins_encoder #(
      .DSCR0_ADDR (DSCR0_ADDR),
      .DSCR1_ADDR (DSCR1_ADDR)
   ) u_enc (
      .op    (enc_op),
      .step  (enc_step),
      .regno (enc_regno),
      .enc   (enc)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         CMD_READY  <= 1'b1;
         INS_VALID  <= 1'b0;
         DSCR_WE    <= 1'b0;
         DSCR_WDATA <= '0;
         RSP_VALID  <= 1'b0;
         RSP_ERR    <= 1'b0;
         RSP_DATA   <= '0;
         op_q       <= '0;
         regno_q    <= '0;
         step_q     <= '0;
         timer      <= '0;
         err_q      <= 1'b0;
         cur_q      <= '0;
      end else begin
         DSCR_WE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (CMD_VALID) begin
                  CMD_READY  <= 1'b0;
                  op_q       <= CMD_OP;
                  regno_q    <= CMD_REGNO;
                  DSCR_WDATA <= CMD_DATA;
                  step_q     <= '0;
                  err_q      <= 1'b0;
                  if (!op_legal(CMD_OP) || (is_gpr(CMD_OP) && (CMD_REGNO > 12'd31))) begin
                     state     <= S_RESP;
                     RSP_VALID <= 1'b1;
                     RSP_ERR   <= 1'b1;
                     RSP_DATA  <= '0;
                  end else if ((CMD_OP == OP_GPR_WR) && (CMD_REGNO == '0)) begin
                     state     <= S_RESP;
                     RSP_VALID <= 1'b1;
                     RSP_ERR   <= 1'b0;
                     RSP_DATA  <= '0;
                  end else if (needs_preload(CMD_OP)) begin
                     state   <= S_PRELOAD;
                     DSCR_WE <= 1'b1;
                  end else begin
                     state     <= S_ISSUE;
                     INS_VALID <= 1'b1;
                     cur_q     <= enc;
                  end
               end
            end
            S_PRELOAD: begin
               state     <= S_ISSUE;
               INS_VALID <= 1'b1;
               cur_q     <= enc;
            end
            S_ISSUE: begin
               if (INS_READY) begin
                  INS_VALID <= 1'b0;
                  timer     <= '0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               timer <= timer + TMR_W'(1);
               // A trap or timeout still restores x8 once it has been saved.
               if (wait_err) begin
                  err_q <= 1'b1;
                  if (can_restore) begin
                     step_q    <= restore_step(op_q);
                     state     <= S_ISSUE;
                     INS_VALID <= 1'b1;
                     cur_q     <= enc;
                  end else begin
                     state     <= S_RESP;
                     RSP_VALID <= 1'b1;
                     RSP_ERR   <= 1'b1;
                     RSP_DATA  <= is_read(op_q) ? DSCR_RDATA : '0;
                  end
               end else if (RETIRE) begin
                  if (cur_q.last) begin
                     state     <= S_RESP;
                     RSP_VALID <= 1'b1;
                     RSP_ERR   <= err_q;
                     RSP_DATA  <= is_read(op_q) ? DSCR_RDATA : '0;
                  end else begin
                     step_q    <= STEP_W'(step_q + 3'd1);
                     state     <= S_ISSUE;
                     INS_VALID <= 1'b1;
                     cur_q     <= enc;
                  end
               end
            end
            S_RESP: begin
               if (RSP_READY) begin
                  RSP_VALID <= 1'b0;
                  RSP_ERR   <= 1'b0;
                  RSP_DATA  <= '0;
                  CMD_READY <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_ins_injector.sv
// Directed bench for dbg_ins_injector; expected instruction words are hand-encoded.
// Honors DBG_INJ_MEM_EN to pick the MEM_RD scenario.
module tb_dbg_ins_injector;

   localparam int unsigned TO = 256;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CMD_VALID, CMD_READY;
   logic [2:0]  CMD_OP;
   logic [11:0] CMD_REGNO;
   logic [31:0] CMD_DATA;
   logic        INS_VALID, INS_READY;
   logic [31:0] INS_OUT;
   logic        RETIRE, EXC;
   logic        DSCR_WE;
   logic [31:0] DSCR_WDATA, DSCR_RDATA;
   logic        RSP_VALID, RSP_READY;
   logic [31:0] RSP_DATA;
   logic        RSP_ERR;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   dbg_ins_injector #(.TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
      .CMD_REGNO(CMD_REGNO), .CMD_DATA(CMD_DATA),
      .INS_VALID(INS_VALID), .INS_READY(INS_READY), .INS_OUT(INS_OUT),
      .RETIRE(RETIRE), .EXC(EXC),
      .DSCR_WE(DSCR_WE), .DSCR_WDATA(DSCR_WDATA), .DSCR_RDATA(DSCR_RDATA),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
      .RSP_ERR(RSP_ERR)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [11:0] regno, input logic [31:0] data);
      check("cmd_ready", 32'(CMD_READY), 32'd1);
      CMD_VALID = 1'b1; CMD_OP = op; CMD_REGNO = regno; CMD_DATA = data;
      cyc();
      CMD_VALID = 1'b0;
   endtask

   task automatic wait_ins(input string tag);
      for (int i = 0; i < 20 && !INS_VALID; i++) cyc();
      check({tag, "_valid"}, 32'(INS_VALID), 32'd1);
   endtask

   // Handshake one instruction; optionally pulse RETIRE in the first WAIT cycle.
   task automatic expect_ins(input string tag, input logic [31:0] word, input bit do_retire);
      wait_ins(tag);
      check(tag, INS_OUT, word);
      INS_READY = 1'b1;
      cyc();
      INS_READY = 1'b0;
      if (do_retire) begin
         RETIRE = 1'b1;
         cyc();
         RETIRE = 1'b0;
      end
   endtask

   task automatic expect_rsp(input string tag, input logic [31:0] data, input logic err,
                             input bit chk_data, input int limit);
      for (int i = 0; i < limit && !RSP_VALID; i++) cyc();
      check({tag, "_valid"}, 32'(RSP_VALID), 32'd1);
      if (chk_data) check({tag, "_data"}, RSP_DATA, data);
      check({tag, "_err"}, 32'(RSP_ERR), 32'(err));
      RSP_READY = 1'b1;
      cyc();
      RSP_READY = 1'b0;
   endtask

   initial begin
      int k;
      RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_REGNO = '0; CMD_DATA = '0;
      INS_READY = 1'b0; RETIRE = 1'b0; EXC = 1'b0; DSCR_RDATA = '0; RSP_READY = 1'b0;
      repeat (3) cyc();
      check("rst_cmd_ready", 32'(CMD_READY), 32'd1);
      check("rst_ins_valid", 32'(INS_VALID), 32'd0);
      check("rst_ins_out",   INS_OUT,        32'd0);
      check("rst_dscr_we",   32'(DSCR_WE),   32'd0);
      check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
      check("rst_rsp_err",   32'(RSP_ERR),   32'd0);
      check("rst_rsp_data",  RSP_DATA,       32'd0);
      RST = 1'b0;
      cyc();

      // GPR_RD x5
      send_cmd(3'd0, 12'd5, 32'd0);
      DSCR_RDATA = 32'hDEADBEEF;
      expect_ins("gpr_rd_x5", 32'h7B229073, 1'b1);
      check("gpr_rd_no_reissue", 32'(INS_VALID), 32'd0);
      expect_rsp("gpr_rd_rsp", 32'hDEADBEEF, 1'b0, 1'b1, 10);

      // GPR_RD x31 (upper legal index) and x32 (illegal)
      send_cmd(3'd0, 12'd31, 32'd0);
      DSCR_RDATA = 32'h0000_0031;
      expect_ins("gpr_rd_x31", 32'h7B2F9073, 1'b1);
      expect_rsp("gpr_rd_x31_rsp", 32'h0000_0031, 1'b0, 1'b1, 10);
      send_cmd(3'd0, 12'd32, 32'd0);
      check("gpr_x32_no_ins", 32'(INS_VALID), 32'd0);
      expect_rsp("gpr_x32_rsp", 32'd0, 1'b1, 1'b1, 1);

      // GPR_WR x7: one preload cycle then the csrrs
      send_cmd(3'd1, 12'd7, 32'h12345678);
      check("gpr_wr_dscr_we", 32'(DSCR_WE), 32'd1);
      check("gpr_wr_wdata", DSCR_WDATA, 32'h12345678);
      check("gpr_wr_no_ins_yet", 32'(INS_VALID), 32'd0);
      cyc();
      check("gpr_wr_we_drop", 32'(DSCR_WE), 32'd0);
      expect_ins("gpr_wr_x7", 32'h7B2023F3, 1'b1);
      expect_rsp("gpr_wr_rsp", 32'd0, 1'b0, 1'b1, 10);

      // GPR_WR x0: answered without injecting
      send_cmd(3'd1, 12'd0, 32'hFFFF_FFFF);
      check("gpr_wr_x0_no_ins", 32'(INS_VALID), 32'd0);
      check("gpr_wr_x0_no_we", 32'(DSCR_WE), 32'd0);
      expect_rsp("gpr_wr_x0_rsp", 32'd0, 1'b0, 1'b1, 1);

      // CSR_RD 0x300 with INS_READY stalled and a slow RETIRE
      send_cmd(3'd2, 12'h300, 32'd0);
      wait_ins("csr_rd_w0");
      for (int i = 0; i < 3; i++) begin
         check("csr_rd_stall_word", INS_OUT, 32'h7B341073);
         check("csr_rd_stall_valid", 32'(INS_VALID), 32'd1);
         cyc();
      end
      INS_READY = 1'b1; cyc(); INS_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("csr_rd_one_in_flight", 32'(INS_VALID), 32'd0);
         cyc();
      end
      RETIRE = 1'b1; cyc(); RETIRE = 1'b0;
      expect_ins("csr_rd_w1", 32'h30002473, 1'b1);
      expect_ins("csr_rd_w2", 32'h7B241073, 1'b1);
      DSCR_RDATA = 32'h0000_1800;
      expect_ins("csr_rd_w3", 32'h7B302473, 1'b1);
      expect_rsp("csr_rd_rsp", 32'h0000_1800, 1'b0, 1'b1, 10);

      // CSR_WR 0x305
      send_cmd(3'd3, 12'h305, 32'h0000_0100);
      check("csr_wr_wdata", DSCR_WDATA, 32'h0000_0100);
      expect_ins("csr_wr_w0", 32'h7B341073, 1'b1);
      expect_ins("csr_wr_w1", 32'h7B202473, 1'b1);
      expect_ins("csr_wr_w2", 32'h30541073, 1'b1);
      expect_ins("csr_wr_w3", 32'h7B302473, 1'b1);
      expect_rsp("csr_wr_rsp", 32'd0, 1'b0, 1'b1, 10);

      // CSR_RD 0x300 trapping on the second word: jump to restore, then error
      send_cmd(3'd2, 12'h300, 32'd0);
      expect_ins("csr_exc_w0", 32'h7B341073, 1'b1);
      expect_ins("csr_exc_w1", 32'h30002473, 1'b0);
      EXC = 1'b1; cyc(); EXC = 1'b0;
      expect_ins("csr_exc_restore", 32'h7B302473, 1'b1);
      expect_rsp("csr_exc_rsp", 32'd0, 1'b1, 1'b0, 10);

      // GPR_RD with no RETIRE: error exactly TO cycles after the handshake
      send_cmd(3'd0, 12'd5, 32'd0);
      wait_ins("to_w0");
      INS_READY = 1'b1; cyc(); INS_READY = 1'b0;
      k = 0;
      while (!RSP_VALID && k < TO + 50) begin
         cyc();
         k++;
      end
      check("timeout_cycles", 32'(k), 32'(TO));
      check("timeout_no_reissue", 32'(INS_VALID), 32'd0);
      expect_rsp("timeout_rsp", 32'd0, 1'b1, 1'b0, 1);

      // Illegal op 7
      send_cmd(3'd7, 12'd0, 32'd0);
      check("op7_no_ins", 32'(INS_VALID), 32'd0);
      expect_rsp("op7_rsp", 32'd0, 1'b1, 1'b1, 1);

`ifdef DBG_INJ_MEM_EN
      send_cmd(3'd4, 12'd0, 32'h80000010);
      check("mem_rd_dscr_we", 32'(DSCR_WE), 32'd1);
      check("mem_rd_wdata", DSCR_WDATA, 32'h80000010);
      expect_ins("mem_rd_w0", 32'h7B341073, 1'b1);
      expect_ins("mem_rd_w1", 32'h7B202473, 1'b1);
      expect_ins("mem_rd_lw", 32'h00042403, 1'b1);
      expect_ins("mem_rd_w3", 32'h7B241073, 1'b1);
      DSCR_RDATA = 32'hCAFE_F00D;
      expect_ins("mem_rd_w4", 32'h7B302473, 1'b1);
      expect_rsp("mem_rd_rsp", 32'hCAFE_F00D, 1'b0, 1'b1, 10);
`else
      send_cmd(3'd4, 12'd0, 32'h80000010);
      check("op4_no_ins", 32'(INS_VALID), 32'd0);
      check("op4_no_we", 32'(DSCR_WE), 32'd0);
      expect_rsp("op4_rsp", 32'd0, 1'b1, 1'b1, 1);
`endif

      // Reset while waiting for a retire abandons the sequence
      send_cmd(3'd2, 12'h300, 32'd0);
      expect_ins("rst_mid_w0", 32'h7B341073, 1'b0);
      cyc();
      RST = 1'b1;
      #1;
      check("midrst_cmd_ready", 32'(CMD_READY), 32'd1);
      check("midrst_ins_valid", 32'(INS_VALID), 32'd0);
      check("midrst_ins_out",   INS_OUT,        32'd0);
      check("midrst_rsp_valid", 32'(RSP_VALID), 32'd0);
      check("midrst_rsp_err",   32'(RSP_ERR),   32'd0);
      check("midrst_rsp_data",  RSP_DATA,       32'd0);
      check("midrst_dscr_we",   32'(DSCR_WE),   32'd0);
      cyc();
      RST = 1'b0;
      cyc();
      send_cmd(3'd0, 12'd1, 32'd0);
      DSCR_RDATA = 32'h0000_0001;
      expect_ins("post_rst_x1", 32'h7B209073, 1'b1);
      expect_rsp("post_rst_rsp", 32'h0000_0001, 1'b0, 1'b1, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
